addsub_rr_scheduler: RTL and testbench

//  Shares one combinational 16-bit add/sub unit between NREQ requesters.
//  - Round-robin arbitration; one operation in flight at a time.
//  - Registers operands, result, carry, overflow and requester ID.
//  - Returns the result over a valid/ready response channel.
//  - Sits between the ALU-using control blocks and the shared add/sub datapath.

---
 rtl/addsub_sched_pkg.sv | 17 +
 rtl/adder_16bit_b.sv | 16 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/addsub_rr_scheduler.sv | 125 ++++++++++++
 tb/tb_addsub_rr_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_sched_pkg.sv
// rtl/addsub_sched_pkg.sv - shared types and constants for the add/sub round-robin scheduler
package addsub_sched_pkg;

  localparam int W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Requester index width; a single requester still needs one ID bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_16bit_b.sv
// rtl/adder_16bit_b.sv - shared 16-bit adder/subtractor (add_ctrl=1 computes a + ~b + 1)
module adder_16bit_b (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        add_ctrl_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [16:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i ^ {16{add_ctrl_i}}} + {16'd0, add_ctrl_i};
  assign sum_o  = full[15:0];
  assign cout_o = full[16];

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, wrapping
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// rtl/addsub_rr_scheduler.sv - round-robin sharing of one 16-bit add/sub unit among NREQ requesters
module addsub_rr_scheduler
  import addsub_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic [15:0]       op_count
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  id_q;
  logic [W-1:0]    a_q, b_q;
  logic            sub_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [W-1:0]    rsp_sum_q;
  logic            rsp_cout_q, rsp_ovf_q;
  logic [15:0]     op_count_q;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic            grant_en, accept, rsp_hs;
  logic [W-1:0]    unit_sum;
  logic            unit_cout, ovf_w;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  adder_16bit_b u_unit (
    .a_i        (a_q),
    .b_i        (b_q),
    .add_ctrl_i (sub_q),
    .sum_o      (unit_sum),
    .cout_o     (unit_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = arb_any ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new op may be granted on the same edge the pending response is taken.
  always_comb begin
    grant_en  = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    req_ready = grant_en ? arb_grant : '0;
    rsp_valid = (state_q == RESP);
  end

  assign accept = grant_en && arb_any;
  assign rsp_hs = rsp_valid && rsp_ready;

  // Overflow is derived from the registered operands, not from the unit.
  assign ovf_w = sub_q ? ((a_q[W-1] != b_q[W-1]) && (unit_sum[W-1] != a_q[W-1]))
                       : ((a_q[W-1] == b_q[W-1]) && (unit_sum[W-1] != a_q[W-1]));

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      if (accept) begin
        a_q      <= req_a[arb_idx*W +: W];
        b_q      <= req_b[arb_idx*W +: W];
        sub_q    <= req_sub[arb_idx];
        id_q     <= arb_idx;
        rr_ptr_q <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
      end
      if (state_q == EXEC) begin
        rsp_sum_q  <= unit_sum;
        rsp_cout_q <= unit_cout;
        rsp_ovf_q  <= ovf_w;
        rsp_id_q   <= id_q;
      end
      if (rsp_hs) op_count_q <= op_count_q + 16'd1;
    end
  end

  assign rsp_id   = rsp_id_q;
  assign rsp_sum  = rsp_sum_q;
  assign rsp_cout = rsp_cout_q;
  assign rsp_ovf  = rsp_ovf_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// tb/tb_addsub_rr_scheduler.sv - scoreboard bench for addsub_rr_scheduler
module tb_addsub_rr_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  typedef struct {
    int          id;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_sub = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              rsp_ovf;
  logic [15:0]       op_count;

  addsub_rr_scheduler #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t exp_q[$];

  // Reference model state: op in the unit, response outstanding, pointer, count.
  bit          m_busy = 0;
  bit          m_resp = 0;
  int          m_ptr  = 0;
  logic [15:0] m_count = '0;
  int          last_grant = -1;
  bit          auto_refill = 0;
  bit          rand_mode = 0;
  bit          mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t ref_op(input int id, input logic [15:0] a, input logic [15:0] b,
                                  input logic sub);
    exp_t e;
    int ua, ub, r, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    r  = sub ? (ua - ub + 65536) : (ua + ub);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    sr = sub ? (sa - sb) : (sa + sb);
    e.id   = id;
    e.sum  = 16'(r);
    e.cout = (r >= 65536);
    e.ovf  = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sub[i]      = s;
    req_valid[i]    = 1'b1;
  endtask

  // Runs at the falling edge: predicts the coming rising edge from the current inputs.
  task automatic model_cycle();
    logic [NREQ-1:0] exp_rdy;
    int g, j;
    bit next_resp;
    exp_rdy = '0;
    g = -1;
    if (!m_busy && (!m_resp || rsp_ready)) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(m_resp));
    check("op_count", 32'(op_count), 32'(m_count));
    if (rst) begin
      m_busy = 0; m_resp = 0; m_ptr = 0; m_count = '0; last_grant = -1;
      exp_q.delete();
    end else begin
      if (m_resp && rsp_ready) m_count++;
      if (g >= 0) begin
        exp_q.push_back(ref_op(g, req_a[g*W +: W], req_b[g*W +: W], req_sub[g]));
        m_ptr = (g + 1) % NREQ;
      end
      next_resp  = m_busy || (m_resp && !rsp_ready);
      m_busy     = (g >= 0);
      m_resp     = next_resp;
      last_grant = g;
    end
  endtask

  task automatic post_edge();
    if (last_grant >= 0) begin
      if (auto_refill) set_req(last_grant, rand16(), rand16(), 1'($urandom));
      else             req_valid[last_grant] = 1'b0;
    end
    if (rand_mode) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, rand16(), rand16(), 1'($urandom));
        else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    post_edge();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input int id, input logic [15:0] sum,
                            input logic cout, input logic ovf, input int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 8) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_sum"}, 32'(rsp_sum), 32'(sum));
    check({tag, "_cout"}, 32'(rsp_cout), 32'(cout));
    check({tag, "_ovf"}, 32'(rsp_ovf), 32'(ovf));
  endtask

  // Scoreboard monitor: compares every presented response with the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && !rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL rsp_unexpected: got id %0d sum 0x%0h, required no response", rsp_id, rsp_sum);
      end else begin
        e = exp_q[0];
        check("sb_id", 32'(rsp_id), 32'(e.id));
        check("sb_sum", 32'(rsp_sum), 32'(e.sum));
        check("sb_cout", 32'(rsp_cout), 32'(e.cout));
        check("sb_ovf", 32'(rsp_ovf), 32'(e.ovf));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    int seen_id[5];
    int seen_cyc[5];
    int nseen;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_req_ready", 32'(req_ready), 0);
    check("reset_rsp_id", 32'(rsp_id), 0);
    check("reset_rsp_sum", 32'(rsp_sum), 0);
    check("reset_rsp_cout", 32'(rsp_cout), 0);
    check("reset_rsp_ovf", 32'(rsp_ovf), 0);
    check("reset_op_count", 32'(op_count), 0);

    // Single add
    set_req(0, 16'h1234, 16'h0FFF, 1'b0);
    expect_rsp("t1", 0, 16'h2233, 1'b0, 1'b0, 2);
    step();
    check("t1_op_count", 32'(op_count), 1);

    // Overflow and carry corners
    set_req(1, 16'h7FFF, 16'h0001, 1'b0);
    expect_rsp("t2a", 1, 16'h8000, 1'b0, 1'b1, 2);
    step();
    set_req(2, 16'h8000, 16'h0001, 1'b1);
    expect_rsp("t2b", 2, 16'h7FFF, 1'b1, 1'b1, 2);
    step();
    set_req(3, 16'h0000, 16'h0001, 1'b1);
    expect_rsp("t2c", 3, 16'hFFFF, 1'b0, 1'b0, 2);
    step();

    // Round-robin with all requesters busy
    do_reset();
    auto_refill = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, rand16(), rand16(), 1'($urandom));
    nseen = 0;
    for (int c = 0; c < 40 && nseen < 5; c++) begin
      step();
      if (rsp_valid) begin
        seen_id[nseen]  = int'(rsp_id);
        seen_cyc[nseen] = c;
        nseen++;
      end
    end
    auto_refill = 1'b0;
    check("t3_count", 32'(nseen), 5);
    for (int i = 0; i < nseen; i++) begin
      check("t3_rr_id", 32'(seen_id[i]), 32'(exp_ids[i]));
      if (i > 0) check("t3_spacing", 32'(seen_cyc[i] - seen_cyc[i-1]), 2);
    end

    // Backpressure with requesters 1 and 2 pending
    do_reset();
    set_req(0, 16'h0003, 16'h0004, 1'b0);
    expect_rsp("t4a", 0, 16'h0007, 1'b0, 1'b0, 2);
    rsp_ready = 1'b0;
    set_req(1, 16'h0010, 16'h0020, 1'b0);
    set_req(2, 16'h0100, 16'h0005, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("t4_hold_valid", 32'(rsp_valid), 1);
      check("t4_hold_sum", 32'(rsp_sum), 32'h0007);
      check("t4_hold_id", 32'(rsp_id), 0);
      check("t4_hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    step();
    check("t4_drop_valid", 32'(rsp_valid), 0);
    expect_rsp("t4b", 1, 16'h0030, 1'b0, 1'b0, 1);
    step();
    expect_rsp("t4c", 2, 16'h00FB, 1'b1, 1'b0, 1);
    step();

    // Reset while the unit is executing
    do_reset();
    set_req(3, 16'h1111, 16'h2222, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rsp_valid", 32'(rsp_valid), 0);
    check("t5_op_count", 32'(op_count), 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_no_rsp", 32'(rsp_valid), 0);
    end
    set_req(3, 16'h1111, 16'h2222, 1'b0);
    set_req(1, 16'h0001, 16'h0001, 1'b0);
    set_req(0, 16'h0100, 16'h0001, 1'b1);
    expect_rsp("t5", 0, 16'h00FF, 1'b1, 1'b0, 2);
    repeat (8) step();

    // op_count wrap
    do_reset();
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    m_count = 16'hFFFE;
    set_req(2, 16'hAAAA, 16'h5555, 1'b0);
    expect_rsp("t6a", 2, 16'hFFFF, 1'b0, 1'b0, 2);
    step();
    check("t6_count_ffff", 32'(op_count), 32'hFFFF);
    set_req(2, 16'hFFFF, 16'h0001, 1'b0);
    expect_rsp("t6b", 2, 16'h0000, 1'b1, 1'b0, 2);
    step();
    check("t6_count_wrap", 32'(op_count), 0);

    // Randomized traffic with random backpressure
    do_reset();
    rand_mode = 1'b1;
    repeat (600) step();
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (10) step();
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
